// File: rtl/ir_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ir_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StByte  = 2'd1,
        StReady = 2'd2
    } fetch_state_e;

    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam logic [31:0] INSTR_RESET     = 32'h0;

endpackage

// File: rtl/ir_fetch.sv
// Instruction fetch: reads four big-endian bytes over req/ack into the instruction register.
// Optional per-byte ack timeout is enabled with macro FETCH_TIMEOUT_EN.
module ir_fetch
    import ir_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] addr,
    input  logic              fetch_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    input  logic              IRWre,
    output logic [31:0]       instr,
    output logic              ready,
    output logic              busy,
    output logic              misalign,
    output logic              fault
);

    localparam logic [1:0] LastIdx = 2'(BYTES_PER_INSTR - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [31:0]       instr_q, instr_d;
    logic              ready_q, ready_d;
    logic              misalign_q, misalign_d;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_q, wait_d;
    logic       fault_q, fault_d;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        instr_d    = instr_q;
        ready_d    = ready_q;
        misalign_d = misalign_q;
`ifdef FETCH_TIMEOUT_EN
        wait_d     = wait_q;
        fault_d    = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (fetch_start) begin
                    if (addr[1:0] == 2'b00) begin
                        base_d     = addr;
                        idx_d      = 2'd0;
                        mem_addr_d = addr;
                        mem_rd_d   = 1'b1;
                        misalign_d = 1'b0;
                        state_d    = StByte;
`ifdef FETCH_TIMEOUT_EN
                        wait_d     = 8'd0;
                        fault_d    = 1'b0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            StByte: begin
                if (mem_rd_q && mem_ack) begin
                    // Lane 3-idx: first byte lands in [31:24] (big-endian).
                    buf_d[{~idx_q, 3'b000} +: 8] = mem_rdata;
`ifdef FETCH_TIMEOUT_EN
                    wait_d = 8'd0;
`endif
                    if (idx_q == LastIdx) begin
                        mem_rd_d = 1'b0;
                        ready_d  = 1'b1;
                        state_d  = StReady;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        mem_addr_d = base_q + ADDR_W'({1'b0, idx_q} + 3'd1);
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_q == WaitLast) begin
                    mem_rd_d = 1'b0;
                    fault_d  = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = StIdle;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            StReady: begin
                if (IRWre) begin
                    instr_d = buf_q;
                    ready_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            base_q     <= '0;
            idx_q      <= 2'd0;
            buf_q      <= 32'h0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            instr_q    <= INSTR_RESET;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            instr_q    <= instr_d;
            ready_q    <= ready_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign fault          = 1'b0;
`endif

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign instr    = instr_q;
    assign ready    = ready_q;
    assign busy     = (state_q != StIdle);
    assign misalign = misalign_q;

endmodule

// File: tb/tb_ir_fetch.sv
// Directed self-checking bench for ir_fetch with a byte-wide memory model.
module tb_ir_fetch;

    logic        CLK;
    logic        RST;
    logic [31:0] addr;
    logic        fetch_start;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        IRWre;
    logic [31:0] instr;
    logic        ready;
    logic        busy;
    logic        misalign;
    logic        fault;

    logic [7:0]  mem [0:255];
    int          n_tests;
    int          n_fail;

    ir_fetch #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (16)
    ) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .addr        (addr),
        .fetch_start (fetch_start),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .IRWre       (IRWre),
        .instr       (instr),
        .ready       (ready),
        .busy        (busy),
        .misalign    (misalign),
        .fault       (fault)
    );

    assign mem_rdata = mem[mem_addr[7:0]];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample/drive 1ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_fetch(input logic [31:0] a);
        addr        = a;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        RST         = 1'b0;
        addr        = 32'h0;
        fetch_start = 1'b0;
        mem_ack     = 1'b0;
        IRWre       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hee;
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        mem[8'h20] = 8'ha1; mem[8'h21] = 8'hb2; mem[8'h22] = 8'hc3; mem[8'h23] = 8'hd4;
        mem[8'h40] = 8'h99; mem[8'h41] = 8'h88; mem[8'h42] = 8'h77; mem[8'h43] = 8'h66;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_flags", {28'h0, ready, busy, misalign, fault}, 32'h0);
        RST = 1'b1;
        tick();

        // Basic fetch, ack tied high
        mem_ack = 1'b1;
        start_fetch(32'h10);
        check_eq("f1_e0_addr", mem_addr, 32'h10);
        check_eq("f1_e0_rd_busy", {30'h0, mem_rd, busy}, 32'h3);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_eq("f1_addr_step", mem_addr, 32'h10 + 32'(e));
            check_eq("f1_not_ready", {31'h0, ready}, 32'h0);
        end
        tick();
        check_eq("f1_e4_ready", {30'h0, ready, mem_rd}, 32'h2);
        check_eq("f1_e4_instr_hold", instr, 32'h0);
        IRWre = 1'b1;
        tick();
        IRWre = 1'b0;
        check_eq("f1_e5_instr", instr, 32'h1234_5678);
        check_eq("f1_e5_idle", {30'h0, ready, busy}, 32'h0);

        // Two idle cycles before each ack
        mem_ack = 1'b0;
        start_fetch(32'h10);
        for (int e = 1; e <= 12; e++) begin
            mem_ack = (e % 3 == 0);
            tick();
            if (e < 12) begin
                check_eq("f2_addr", mem_addr, 32'h10 + 32'(e / 3));
                check_eq("f2_ready_low", {31'h0, ready}, 32'h0);
            end
        end
        mem_ack = 1'b0;
        check_eq("f2_e12_ready", {30'h0, ready, mem_rd}, 32'h2);
        IRWre = 1'b1;
        tick();
        IRWre = 1'b0;
        check_eq("f2_instr", instr, 32'h1234_5678);

        // Misaligned request, then aligned fetch clears the flag
        start_fetch(32'h6);
        check_eq("mis_flag", {31'h0, misalign}, 32'h1);
        check_eq("mis_no_access", {30'h0, mem_rd, busy}, 32'h0);
        check_eq("mis_instr_hold", instr, 32'h1234_5678);
        mem_ack = 1'b1;
        start_fetch(32'h20);
        check_eq("mis_cleared", {31'h0, misalign}, 32'h0);
        repeat (4) tick();
        IRWre = 1'b1;
        tick();
        IRWre = 1'b0;
        check_eq("f3_instr", instr, 32'ha1b2_c3d4);

        // fetch_start while busy is ignored; ready held without IRWre
        mem_ack = 1'b0;
        start_fetch(32'h10);
        addr        = 32'h40;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check_eq("busy_ign_addr", mem_addr, 32'h10);
        mem_ack = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_eq("busy_ign_step", mem_addr, 32'h10 + 32'(e));
        end
        tick();
        check_eq("busy_ign_ready", {31'h0, ready}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("hold_instr", instr, 32'ha1b2_c3d4);
            check_eq("hold_ready", {30'h0, ready, mem_rd}, 32'h2);
        end
        addr        = 32'h20;
        fetch_start = 1'b1;
        IRWre       = 1'b1;
        tick();
        fetch_start = 1'b0;
        IRWre       = 1'b0;
        check_eq("ready_both_instr", instr, 32'h1234_5678);
        check_eq("ready_both_drop", {30'h0, mem_rd, busy}, 32'h0);

        // Asynchronous reset after byte 2
        mem_ack = 1'b1;
        start_fetch(32'h20);
        repeat (2) tick();
        #2;
        RST = 1'b0;
        #1;
        check_eq("arst_rd", {31'h0, mem_rd}, 32'h0);
        check_eq("arst_instr", instr, 32'h0);
        check_eq("arst_ready_busy", {30'h0, ready, busy}, 32'h0);
        tick();
        RST = 1'b1;
        tick();
        start_fetch(32'h10);
        repeat (4) tick();
        IRWre = 1'b1;
        tick();
        IRWre = 1'b0;
        check_eq("arst_refetch", instr, 32'h1234_5678);

        // No ack at all
        mem_ack = 1'b0;
        start_fetch(32'h20);
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        check_eq("to_e15_waiting", {29'h0, mem_rd, busy, fault}, 32'h6);
        tick();
        check_eq("to_e16_abort", {29'h0, mem_rd, busy, fault}, 32'h1);
        check_eq("to_instr_hold", instr, 32'h1234_5678);
        check_eq("to_ready_low", {31'h0, ready}, 32'h0);
        start_fetch(32'h10);
        check_eq("to_fault_clr", {31'h0, fault}, 32'h0);
`else
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c % 25 == 0) check_eq("noto_waiting", {29'h0, mem_rd, busy, fault}, 32'h6);
        end
        check_eq("noto_addr", mem_addr, 32'h20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
